// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a two-state FETCH/ISSUE sequencer that reads one
// instruction word from memory, holds it for decode until retired, then
// computes the next PC (sequential, taken branch, or J-type jump).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  op_code,
  output logic [31:0] pc_plus4,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        br_cond
);

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // The PC is kept word-aligned even if RESET_PC is given unaligned.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  // run_q holds the request off during the first cycle after reset release,
  // so imem_req first rises on the first clock edge once rst_n is high.
  logic        run_q, run_d;

  logic [31:0] pc_plus4_w;
  logic [31:0] br_offset;
  logic [31:0] next_pc;

  assign pc_plus4_w = pc_q + 32'd4;
  assign br_offset  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Next-PC selection used at retire: jump beats branch, branch only if taken.
  always_comb begin
    next_pc = pc_plus4_w;
    if (Jump) begin
      next_pc = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
    end else if (Branch && br_cond) begin
      next_pc = pc_plus4_w + br_offset;
    end
  end

  // Next-state and output logic for the FETCH/ISSUE sequencer.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    run_d       = 1'b1;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = run_q;
        // An ack is only meaningful while a request is actually outstanding.
        if (run_q && imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        // Branch/Jump/br_cond are only looked at here, on the retire cycle.
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= 32'h0000_0000;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      run_q   <= run_d;
    end
  end

  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign op_code   = instr_q[31:26];
  assign pc_plus4  = pc_plus4_w;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word-aligned read address; equals the current PC.
REQ-007 imem_ack  input  1  read complete; imem_rdata is valid this cycle.
REQ-008 imem_rdata  input  32  instruction word returned by memory.
REQ-009 instr_valid  output  1  instr, op_code and pc_plus4 are valid for decode.
REQ-010 instr_ready  input  1  decode/execute accepts (retires) the held instruction.
REQ-011 instr  output  32  held instruction word.
REQ-012 op_code  output  6  instr[31:26]; drives the op_code input of the MCU.
REQ-013 pc_plus4  output  32  PC of the held instruction + 4.
REQ-014 Branch  input  1  from the MCU; the held instruction is a conditional branch.
REQ-015 Jump  input  1  from the MCU; the held instruction is a J-type jump.
REQ-016 br_cond  input  1  branch condition resolved true (BEQ equal, BNE not-equal, REGIMM as decoded).

Function
REQ-017 The block SHALL be an FSM with two states: FETCH and ISSUE.
REQ-018 In FETCH: imem_req=1, imem_addr=pc, instr_valid=0.
REQ-019 In FETCH, imem_req and imem_addr SHALL stay asserted and stable until imem_ack=1.
REQ-020 On imem_ack=1 in FETCH: instr <= imem_rdata, next state ISSUE; an ack in the first request cycle is legal.
REQ-021 In ISSUE: imem_req=0, instr_valid=1.
REQ-022 While instr_valid=1 and instr_ready=0, instr, op_code, pc_plus4 and pc SHALL hold stable.
REQ-023 Branch, Jump and br_cond SHALL be sampled only in the cycle with instr_valid=1 and instr_ready=1 (retire).
REQ-024 On retire, pc SHALL load next_pc and the state SHALL return to FETCH.
REQ-025 next_pc for Jump=1 SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}; Jump SHALL have priority over Branch.
REQ-026 next_pc for Branch=1 and br_cond=1 SHALL be pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), computed modulo 2^32.
REQ-027 In all other cases next_pc SHALL be pc_plus4.
REQ-028 pc_plus4 SHALL equal pc + 1 address word (pc + 4), modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-029 pc[1:0] SHALL always be 2'b00; every computed target is word-aligned by construction.
REQ-030 imem_ack while in ISSUE SHALL be ignored and SHALL NOT change instr.
REQ-031 instr_ready while in FETCH SHALL be ignored.
REQ-032 Minimum throughput SHALL be one instruction per 2 cycles (ack in first FETCH cycle, ready in first ISSUE cycle).
REQ-033 An unknown op_code (for example 6'b111111, which the MCU decodes as all control bits 0) SHALL retire with next_pc = pc_plus4.

Reset
REQ-034 While rst_n=0, the block SHALL set: state=FETCH, pc=RESET_PC, instr=32'h0000_0000, instr_valid=0, imem_req=0.
REQ-035 imem_req SHALL first assert in the first clk edge after rst_n deasserts; imem_addr=RESET_PC at that time.
REQ-036 Reset asserted mid-fetch or mid-issue SHALL abort immediately; any imem_ack arriving during reset SHALL be ignored.

Verification
REQ-037 Reset release with RESET_PC=0, imem_ack after 3 cycles, rdata=32'h8C08_0004 (LW) -> imem_addr=0 held 3 cycles; then instr_valid=1, op_code=6'b100011, pc_plus4=4.
REQ-038 Sequential: hold at 32'h0000_0010 with Branch=0, Jump=0, ready=1 -> next imem_addr=32'h0000_0014.
REQ-039 BEQ at pc=32'h0000_0020 with instr[15:0]=16'hFFFE, Branch=1, br_cond=1 -> next imem_addr=32'h0000_001C; same instruction with br_cond=0 -> 32'h0000_0024.
REQ-040 J at pc=32'h4000_0000 with instr[25:0]=26'h000_0100 -> next imem_addr=32'h4000_0400; Jump=1 and Branch=1 together -> jump target used.
REQ-041 Backpressure: instr_ready=0 for 5 cycles in ISSUE with a spurious imem_ack -> instr and pc unchanged, imem_req=0 throughout.
REQ-042 rst_n pulsed low during FETCH at pc=32'h0000_0040 -> imem_req=0 and instr_valid=0 immediately; after release, imem_addr=RESET_PC.
